// File: rtl/leitor_load_aste.sv
// Sequential reader for the 16-entry asteroid-load pattern memory: sweeps all entries once per
// start pulse and offers one spawn command per occupied entry over a valid/ready handshake.
module leitor_load_aste #(
  parameter bit CLEAR_ON_READ = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] count_o,
  output logic [3:0] mem_addr_o,
  output logic       mem_we_o,
  output logic [1:0] mem_data_o,
  input  logic [1:0] mem_q_i,
  output logic       spawn_valid_o,
  input  logic       spawn_ready_i,
  output logic [3:0] spawn_slot_o,
  output logic       spawn_kind_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StOffer,
    StClear,
    StDone
  } state_e;

  state_e     state_q;
  logic [3:0] idx_q;
  logic [4:0] count_q;
  logic       busy_q;
  logic       done_q;
  logic       we_q;
  logic       valid_q;
  logic [3:0] slot_q;
  logic       kind_q;
  logic       last_idx;

  assign last_idx = (idx_q == 4'd15);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      count_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      slot_q  <= 4'd0;
      kind_q  <= 1'b0;
    end else begin
      // done and write-enable are single-cycle pulses unless re-armed below
      done_q <= 1'b0;
      we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q   <= 4'd0;
            count_q <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= StAddr;
          end
        end
        StAddr: state_q <= StRead;
        StRead: begin
          // mem_q reflects the address registered by the memory at the ADDR->READ edge
          if (mem_q_i[1]) begin
            kind_q  <= mem_q_i[0];
            slot_q  <= idx_q;
            valid_q <= 1'b1;
            state_q <= StOffer;
          end else if (last_idx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= StAddr;
          end
        end
        StOffer: begin
          if (spawn_ready_i) begin
            valid_q <= 1'b0;
            count_q <= count_q + 5'd1;
            if (CLEAR_ON_READ) begin
              we_q    <= 1'b1;
              state_q <= StClear;
            end else if (last_idx) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StAddr;
            end
          end
        end
        StClear: begin
          if (last_idx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= StAddr;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign count_o       = count_q;
  assign mem_addr_o    = idx_q;
  assign mem_we_o      = we_q;
  assign mem_data_o    = 2'b00;
  assign spawn_valid_o = valid_q;
  assign spawn_slot_o  = slot_q;
  assign spawn_kind_o  = kind_q;

endmodule
